fetch_unit: RTL and testbench

- Instruction fetch front-end for the single-issue LEGv8 core.
- Produces the instruction stream that the control unit decodes: OpCode = instr[31:21], Cond = instr[3:0].
- Consumes the control unit's PCSrc redirect decision.
- Maintains the PC, issues word reads to instruction memory, buffers returned words in a small prefetch queue, and flushes on taken branches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and instruction field positions for the LEGv8 fetch front-end.
package fetch_pkg;
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_REG = 2'b10
  } pcsrc_e;
  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_e;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 21;
  localparam int COND_HI = 3;
  localparam int COND_LO = 0;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch FIFO holding {instr, pc} pairs.
//   clk, rst            : clock, asynchronous active-high reset
//   push/push_instr/pc  : enqueue one fetched word and its address
//   pop                 : dequeue head (caller guarantees non-empty)
//   flush               : empty the queue; wins over push and pop
//   count               : current occupancy
//   head_instr/head_pc  : head entry (undefined while empty)
module fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [INSTR_W-1:0]          push_instr,
  input  logic [PC_W-1:0]             push_pc,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [INSTR_W-1:0]          head_instr,
  output logic [PC_W-1:0]             head_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [INSTR_W+PC_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= {push_instr, push_pc};
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + AW'(pop);
      wr    <= wr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  assign {head_instr, head_pc} = mem[rd];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 instruction fetch front-end with prefetch queue and redirect flush.
//   clk, rst                      : clock, asynchronous active-high reset
//   imem_req/addr/gnt             : word read request handshake to instruction memory
//   imem_rvalid/rdata             : in-order read responses, latency >= 1
//   instr_valid/ready/instr/pc    : head of the prefetch queue toward decode
//   OpCode, Cond                  : instr[31:21], instr[3:0] of the head
//   PCSrc, redirect_valid         : redirect decision from control (01 branch, 10 register)
//   branch_target, reg_target     : redirect targets (low 2 bits ignored)
//   perf_fetched, perf_flushed    : counters, present only when FETCH_PERF_EN is defined
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [10:0]        OpCode,
  output logic [3:0]         Cond,
  input  logic [1:0]         PCSrc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    reg_target,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_e state;
  logic [PC_W-1:0] fetch_pc, req_pc, target, head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [CW-1:0] count;
  logic take, fire, push, pop;
  assign take   = redirect_valid && (PCSrc == PCSRC_BR || PCSrc == PCSRC_REG);
  assign target = PCSrc == PCSRC_BR ? branch_target : reg_target;
  // Only FETCH has no outstanding request, so credit reduces to a free queue slot.
  assign imem_req    = !rst && state == FETCH && count < CW'(DEPTH);
  assign imem_addr   = fetch_pc;
  assign fire        = imem_req && imem_gnt;
  assign push        = state == WAIT && imem_rvalid && !take;
  assign instr_valid = count != '0;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head_instr : '0;
  assign instr_pc    = instr_valid ? head_pc : RESET_PC;
  assign OpCode      = instr[OPC_HI:OPC_LO];
  assign Cond        = instr[COND_HI:COND_LO];
  fetch_queue #(
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W),
    .PC_W   (PC_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (take),
    .push_instr(imem_rdata),
    .push_pc   (req_pc),
    .count     (count),
    .head_instr(head_instr),
    .head_pc   (head_pc)
  );
  // A redirect with a request in flight (or granted now) must swallow its response.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (take) fetch_pc <= target & ~PC_W'(3);
      else if (fire) fetch_pc <= fetch_pc + PC_W'(4);
      if (fire) req_pc <= fetch_pc;
      state <= state == FETCH ? (fire ? (take ? DISCARD : WAIT) : FETCH)
             : imem_rvalid ? FETCH
             : (state == WAIT && !take) ? WAIT : DISCARD;
    end
`ifdef FETCH_PERF_EN
  logic [31:0] fetched, flushed;
  logic flushing;
  // In DISCARD the pending response is already doomed, so it is not counted again.
  assign flushing = take && (count != '0 || state == WAIT || fire);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetched <= '0;
      flushed <= '0;
    end else begin
      fetched <= fetched + 32'(push);
      flushed <= flushed + 32'(flushing);
    end
  assign perf_fetched = fetched;
  assign perf_flushed = flushed;
`else
  assign perf_fetched = '0;
  assign perf_flushed = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk, rst;
  logic imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect_valid;
  logic [63:0] imem_addr, instr_pc, branch_target, reg_target;
  logic [31:0] imem_rdata, instr, perf_fetched, perf_flushed;
  logic [10:0] OpCode;
  logic [3:0] Cond;
  logic [1:0] PCSrc;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .OpCode(OpCode), .Cond(Cond),
    .PCSrc(PCSrc), .redirect_valid(redirect_valid), .branch_target(branch_target),
    .reg_target(reg_target), .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] ins; logic [63:0] pc;} ent_t;
  ent_t q[$];
  logic [63:0] m_pc, p_addr;
  bit pend, drop;
  int m_fetched, m_flushed;
  bit mem_busy;
  int mem_wait, lat_min, lat_max;
  int gnt_mode, ready_mode;
  bit rnd_rv, force_rv, force_stale, fixed_valid;
  logic [1:0] f_src;
  logic [63:0] f_tgt;
  logic [31:0] fixed_data;
  int tests, fails, cyc, grants, gcyc, vcyc, g1;
  bit saw_gnt, saw_valid;
  logic [63:0] last_gaddr, v_pc;
  logic [63:0] gaddrs[$];
  logic [10:0] v_opc;
  logic [3:0] v_cond;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive();
    imem_gnt = gnt_mode == 0 ? 1'b1 : gnt_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    imem_rvalid = force_stale || (mem_busy && mem_wait == 0);
    imem_rdata = fixed_valid ? fixed_data : $urandom;
    if (imem_rvalid && !force_stale) fixed_valid = 0;
    force_stale = 0;
    instr_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    PCSrc = 2'($urandom_range(0, 3));
    branch_target = {$urandom, $urandom};
    reg_target = {$urandom, $urandom};
    redirect_valid = rnd_rv && $urandom_range(0, 7) == 0;
    if (force_rv) begin
      redirect_valid = 1;
      PCSrc = f_src;
      branch_target = f_tgt;
      reg_target = f_tgt;
      force_rv = 0;
    end
  endtask

  task automatic compare();
    bit exp_req;
    cyc++;
    exp_req = !pend && q.size() < DEPTH;
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instr", 64'(instr), 64'(q[0].ins));
      chk("instr_pc", instr_pc, q[0].pc);
      chk("OpCode", 64'(OpCode), 64'(q[0].ins[31:21]));
      chk("Cond", 64'(Cond), 64'(q[0].ins[3:0]));
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`else
    chk("perf_fetched", 64'(perf_fetched), 64'd0);
    chk("perf_flushed", 64'(perf_flushed), 64'd0);
`endif
    if (imem_req && imem_gnt) begin
      saw_gnt = 1;
      last_gaddr = imem_addr;
      gcyc = cyc;
      gaddrs.push_back(imem_addr);
      grants++;
    end
    if (instr_valid && !saw_valid) begin
      saw_valid = 1;
      vcyc = cyc;
      v_opc = OpCode;
      v_cond = Cond;
      v_pc = instr_pc;
    end
  endtask

  task automatic model_update();
    bit req, fire, resp, take, pop;
    req = !pend && q.size() < DEPTH;
    fire = req && imem_gnt;
    resp = pend && imem_rvalid;
    pop = q.size() != 0 && instr_ready;
    take = redirect_valid && (PCSrc == 2'd1 || PCSrc == 2'd2);
    if (take) begin
      if (q.size() != 0 || (pend && !drop) || fire) m_flushed++;
      q.delete();
      m_pc = (PCSrc == 2'd1 ? branch_target : reg_target) & ~64'd3;
      pend = (pend && !resp) || fire;
      drop = pend;
    end else begin
      if (pop) void'(q.pop_front());
      if (resp && !drop) begin
        q.push_back({imem_rdata, p_addr});
        m_fetched++;
      end
      if (resp) begin
        pend = 0;
        drop = 0;
      end
      if (fire) begin
        pend = 1;
        drop = 0;
        p_addr = m_pc;
        m_pc = m_pc + 64'd4;
      end
    end
    if (imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    if (fire) begin
      mem_busy = 1;
      mem_wait = $urandom_range(lat_min, lat_max);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    compare();
    model_update();
  endtask

  task automatic do_reset();
    imem_gnt = 0;
    imem_rvalid = 0;
    redirect_valid = 0;
    instr_ready = 0;
    force_rv = 0;
    force_stale = 0;
    rst = 1;
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_OpCode", 64'(OpCode), 64'd0);
    chk("rst_Cond", 64'(Cond), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    chk("rst_perf_flushed", 64'(perf_flushed), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.delete();
    gaddrs.delete();
    m_pc = 0;
    pend = 0;
    drop = 0;
    mem_busy = 0;
    m_fetched = 0;
    m_flushed = 0;
    grants = 0;
    saw_valid = 0;
  endtask

  task automatic run_until_grant(input string name);
    int n;
    n = 0;
    saw_gnt = 0;
    while (!saw_gnt && n < 200) begin
      step();
      n++;
    end
    chk(name, 64'(saw_gnt), 64'd1);
  endtask

  task automatic run_until_valid(input string name);
    int n;
    n = 0;
    saw_valid = 0;
    while (!saw_valid && n < 200) begin
      step();
      n++;
    end
    chk(name, 64'(saw_valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; cyc = 0;
    rnd_rv = 0; force_rv = 0; force_stale = 0; fixed_valid = 0;
    gnt_mode = 0; ready_mode = 0; lat_min = 0; lat_max = 0;
    PCSrc = 0; branch_target = 0; reg_target = 0; imem_rdata = 0;
    do_reset();

    // Streaming with 1-cycle latency.
    fixed_valid = 1;
    fixed_data = 32'hF2000000;
    run_until_grant("t1_first_grant");
    g1 = gcyc;
    chk("t1_addr0", last_gaddr, 64'h0);
    run_until_valid("t1_first_valid");
    chk("t1_latency", 64'(vcyc - g1), 64'd2);
    chk("t1_OpCode", 64'(v_opc), 64'(11'b11110010000));
    chk("t1_Cond", 64'(v_cond), 64'd0);
    repeat (4) step();
    chk("t1_addr1", gaddrs[1], 64'h4);
    chk("t1_addr2", gaddrs[2], 64'h8);

    // Back-pressure fills the queue then stops requesting.
    do_reset();
    ready_mode = 1;
    repeat (12) step();
    chk("t2_grants", 64'(grants), 64'd2);
    chk("t2_req_idle", 64'(imem_req), 64'd0);
    ready_mode = 0;
    run_until_grant("t2_resume");
    chk("t2_resume_addr", last_gaddr, 64'h8);

    // PC-relative redirect while a request is outstanding.
    do_reset();
    lat_min = 2; lat_max = 2;
    run_until_grant("t3_grant");
    force_rv = 1; f_src = 2'b01; f_tgt = 64'h103;
    step();
    step();
    chk("t3_flushed", 64'(instr_valid), 64'd0);
    run_until_grant("t3_regrant");
    chk("t3_target_addr", last_gaddr, 64'h100);
    run_until_valid("t3_valid");
    chk("t3_instr_pc", v_pc, 64'h100);

    // Register redirect from idle, then reserved PCSrc.
    do_reset();
    gnt_mode = 1; ready_mode = 1; lat_min = 0; lat_max = 0;
    step();
    force_rv = 1; f_src = 2'b10; f_tgt = 64'h2000;
    step();
    step();
    chk("t4_req", 64'(imem_req), 64'd1);
    chk("t4_addr", imem_addr, 64'h2000);
    gnt_mode = 0;
    run_until_grant("t4_grant");
    gnt_mode = 1;
    run_until_valid("t4_valid");
    chk("t4_valid_pc", v_pc, 64'h2000);
    force_rv = 1; f_src = 2'b11; f_tgt = 64'h5550;
    step();
    step();
    chk("t4_no_flush", 64'(instr_valid), 64'd1);
    chk("t4_no_flush_pc", instr_pc, 64'h2000);

    // Asynchronous reset in the middle of WAIT, then a stale response.
    do_reset();
    gnt_mode = 0; ready_mode = 1; lat_min = 3; lat_max = 3;
    run_until_valid("t5_valid");
    @(posedge clk);
    #2;
    chk("t5_pre_req", 64'(imem_req), 64'd0);
    chk("t5_pre_valid", 64'(instr_valid), 64'd1);
    do_reset();
    gnt_mode = 1;
    force_stale = 1;
    step();
    step();
    chk("t5_stale_dropped", 64'(instr_valid), 64'd0);
    gnt_mode = 0;
    run_until_grant("t5_restart");
    chk("t5_restart_addr", last_gaddr, 64'h0);

    // Perf counters: 5 pushes and 2 flushing redirects.
    do_reset();
    gnt_mode = 0; ready_mode = 1; lat_min = 0; lat_max = 0;
    repeat (10) step();
    force_rv = 1; f_src = 2'b01; f_tgt = 64'h40;
    step();
    repeat (10) step();
    force_rv = 1; f_src = 2'b10; f_tgt = 64'h80;
    step();
    run_until_grant("t6_grant");
    gnt_mode = 1;
    repeat (5) step();
`ifdef FETCH_PERF_EN
    chk("t6_perf_fetched", 64'(perf_fetched), 64'd5);
    chk("t6_perf_flushed", 64'(perf_flushed), 64'd2);
`else
    chk("t6_perf_fetched", 64'(perf_fetched), 64'd0);
    chk("t6_perf_flushed", 64'(perf_flushed), 64'd0);
`endif

    // Random traffic.
    do_reset();
    gnt_mode = 2; ready_mode = 2; lat_min = 0; lat_max = 3; rnd_rv = 1;
    repeat (3000) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
